watch_set_ctrl: RTL and testbench

- Mode/set controller for the watch time-counter chain (sec/min/hour counters).
- In RUN, forwards the timebase tick to the chain. In a SET mode, blocks the tick and turns "up" button presses into one-clock increment pulses on the counter's run input for the selected field.
- Sits between the debounced buttons/tick generator and the counter instances. Also drives display blink and field select.

---
 rtl/watch_set_ctrl.sv | 154 +++++++++++++++
 tb/tb_watch_set_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Mode/set controller for the watch sec/min/hour counter chain: gates the timebase tick,
// turns up-button presses into increment pulses, drives blink and field select.
// Optional hold-to-repeat on the up button: define WATCH_AUTOREPEAT_EN.

module watch_set_ctrl #(
  parameter int TIMEOUT_TICKS = 1000,
  parameter int BLINK_TICKS   = 50,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_RATE   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  output logic       o_tick,
  output logic       o_run_sec,
  output logic       o_run_min,
  output logic       o_run_hour,
  output logic [1:0] o_set_field,
  output logic       o_blink
);

  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_TICKS - 1);

  // State encoding doubles as the field-select code seen by the display.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            mode_q, up_q;
  logic            mode_evt, up_edge, up_evt, rep_evt, timeout_hit, in_set;
  logic [TW-1:0]   tcnt_q;
  logic [BW-1:0]   bcnt_q;
  logic            blink_q;

  always_comb begin
    in_set      = (state_q != RUN);
    mode_evt    = i_btn_mode & ~mode_q;
    up_edge     = i_btn_up & ~up_q;
    up_evt      = in_set & ~mode_evt & (up_edge | rep_evt);
    timeout_hit = in_set & i_tick & ~mode_evt & ~up_evt & (tcnt_q == TMAX);
    state_d     = state_q;
    if (mode_evt) begin
      unique case (state_q)
        RUN:      state_d = SET_SEC;
        SET_SEC:  state_d = SET_MIN;
        SET_MIN:  state_d = SET_HOUR;
        SET_HOUR: state_d = RUN;
      endcase
    end else if (timeout_hit) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      mode_q     <= 1'b0;
      up_q       <= 1'b0;
      o_tick     <= 1'b0;
      o_run_sec  <= 1'b0;
      o_run_min  <= 1'b0;
      o_run_hour <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= i_btn_mode;
      up_q       <= i_btn_up;
      o_tick     <= i_tick & ~in_set;
      o_run_sec  <= up_evt & (state_q == SET_SEC);
      o_run_min  <= up_evt & (state_q == SET_MIN);
      o_run_hour <= up_evt & (state_q == SET_HOUR);
    end
  end

  // Idle timeout: any button activity restarts it; leaving SET parks it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if ((state_d == RUN) || mode_evt || up_evt) begin
      tcnt_q <= '0;
    end else if (i_tick) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // A newly selected or just-incremented field is shown lit before blinking resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (state_d == RUN) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (mode_evt || up_evt) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else if (i_tick) begin
      if (bcnt_q == BMAX) begin
        bcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt_q <= bcnt_q + BW'(1);
      end
    end
  end

`ifdef WATCH_AUTOREPEAT_EN
  localparam int RMAXP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = (RMAXP > 1) ? $clog2(RMAXP) : 1;
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRATE = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rcnt_q;
  logic          rarmed_q;

  always_comb begin
    rep_evt = in_set & i_btn_up & i_tick & (rarmed_q ? (rcnt_q == RRATE) : (rcnt_q == RDLY));
  end

  // First repeat waits the long delay; once armed, repeats at the faster rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q   <= '0;
      rarmed_q <= 1'b0;
    end else if (!i_btn_up || !in_set || (state_d != state_q)) begin
      rcnt_q   <= '0;
      rarmed_q <= 1'b0;
    end else if (i_tick) begin
      if (rep_evt) begin
        rcnt_q   <= '0;
        rarmed_q <= 1'b1;
      end else begin
        rcnt_q <= rcnt_q + RW'(1);
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rep_evt = 1'b0;
`endif

  assign o_set_field = state_q;
  assign o_blink     = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: per-cycle vector tables with a queue of
// expected outputs, plus hand-written reset and auto-repeat sequences.

module tb_watch_set_ctrl;

`ifdef WATCH_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tick = 1'b0;
  logic       i_btn_mode = 1'b0;
  logic       i_btn_up = 1'b0;
  logic       o_tick, o_run_sec, o_run_min, o_run_hour, o_blink;
  logic [1:0] o_set_field;

  watch_set_ctrl #(
    .TIMEOUT_TICKS(5),
    .BLINK_TICKS  (3),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (i_tick),
    .i_btn_mode (i_btn_mode),
    .i_btn_up   (i_btn_up),
    .o_tick     (o_tick),
    .o_run_sec  (o_run_sec),
    .o_run_min  (o_run_min),
    .o_run_hour (o_run_hour),
    .o_set_field(o_set_field),
    .o_blink    (o_blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic       up;
    logic       tick;
    logic       exp_tick;
    logic [2:0] exp_run;
    logic [1:0] exp_field;
    logic       exp_blink;
    logic       chk_blink;
  } vec_t;

  typedef struct {
    logic       tick;
    logic [2:0] run;
    logic [1:0] field;
    logic       blink;
    logic       chk_blink;
    int         idx;
  } exp_t;

  vec_t  tbl[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    pulses = 0;
  bit    count_en = 1'b0;
  string phase = "none";

  // Pulse counter for the held-button sequence, sampled mid-cycle.
  always @(negedge clk) begin
    if (count_en && o_run_sec) pulses++;
  end

  function automatic void add(input logic m, input logic u, input logic t, input logic et,
                              input logic [2:0] er, input logic [1:0] ef, input logic eb,
                              input logic cb);
    vec_t v;
    v.mode = m; v.up = u; v.tick = t;
    v.exp_tick = et; v.exp_run = er; v.exp_field = ef; v.exp_blink = eb; v.chk_blink = cb;
    tbl.push_back(v);
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic bad;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, got tick=%b run=%b field=%0d", phase, o_tick,
               {o_run_hour, o_run_min, o_run_sec}, o_set_field);
      return;
    end
    e = exp_q.pop_front();
    bad = (o_tick !== e.tick) || ({o_run_hour, o_run_min, o_run_sec} !== e.run) ||
          (o_set_field !== e.field) || (e.chk_blink && (o_blink !== e.blink));
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s#%0d: got tick=%b run=%b field=%0d blink=%b, want tick=%b run=%b field=%0d blink=%b",
               phase, e.idx, o_tick, {o_run_hour, o_run_min, o_run_sec}, o_set_field, o_blink,
               e.tick, e.run, e.field, e.blink);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    i_btn_mode = v.mode;
    i_btn_up   = v.up;
    i_tick     = v.tick;
    e.tick = v.exp_tick; e.run = v.exp_run; e.field = v.exp_field;
    e.blink = v.exp_blink; e.chk_blink = v.chk_blink; e.idx = idx;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runTable(input string name);
    phase = name;
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);
    tbl.delete();
  endtask

  task automatic checkIdle(input string name);
    vectors++;
    if ({o_tick, o_run_hour, o_run_min, o_run_sec, o_set_field, o_blink} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL %s: got tick=%b run=%b field=%0d blink=%b, want all zero", name,
               o_tick, {o_run_hour, o_run_min, o_run_sec}, o_set_field, o_blink);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    i_tick = 1'b0; i_btn_mode = 1'b0; i_btn_up = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start, auto-repeat build = %0d", REP);
    doReset();

    // RUN: ticks forwarded one clock later, no run pulses.
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 1, 1, 3'b000, 2'd0, 0, 1);
      add(0, 0, 0, 0, 3'b000, 2'd0, 0, 1);
    end
    runTable("run_ticks");

    // SET_SEC: two up presses five clocks apart, ticks blocked, blink toggles after 3 ticks.
    add(1, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 1, 0, 0, 3'b001, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd1, 0, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 0, 1);
    add(0, 1, 0, 0, 3'b001, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    runTable("set_sec");

    // Mode walk to SET_HOUR, hour increment, back to RUN.
    add(1, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(0, 1, 0, 0, 3'b100, 2'd3, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd0, 0, 1);
    add(0, 0, 0, 0, 3'b000, 2'd0, 0, 1);
    runTable("mode_walk");

    // Timeout out of SET_MIN after 5 idle ticks.
    add(1, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 0, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 0, 1);
    add(0, 0, 1, 0, 3'b000, 2'd0, 0, 1);
    add(0, 0, 1, 1, 3'b000, 2'd0, 0, 1);
    runTable("timeout");

    // Up press together with tick 4 restarts the timeout.
    add(1, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 0, 1);
    add(0, 1, 1, 0, 3'b010, 2'd2, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 0, 1);
    add(0, 0, 1, 0, 3'b000, 2'd2, 0, 1);
    add(0, 0, 1, 0, 3'b000, 2'd0, 0, 1);
    runTable("timeout_restart");

    // Mode and up in the same cycle: mode wins, both from RUN and from SET_HOUR.
    add(1, 1, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(1, 1, 0, 0, 3'b000, 2'd0, 0, 1);
    add(0, 0, 0, 0, 3'b000, 2'd0, 0, 1);
    add(1, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd2, 1, 1);
    add(1, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd3, 1, 1);
    add(0, 1, 0, 0, 3'b100, 2'd3, 1, 1);
    runTable("simultaneous");

    // Asynchronous reset mid-SET_HOUR while an hour pulse is on the output.
    rst = 1'b1;
    i_btn_up = 1'b0;
    #2;
    checkIdle("async_rst");
    repeat (2) @(posedge clk);
    #1;
    checkIdle("async_rst_hold");
    rst = 1'b0;
    exp_q.delete();

    // Up held in SET_SEC across 9 ticks.
    add(1, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 0, 0, 0, 3'b000, 2'd1, 1, 1);
    add(0, 1, 0, 0, 3'b001, 2'd1, 1, 1);
    for (int k = 1; k <= 9; k++) begin
      add(0, 1, 1, (!REP && k >= 6), (REP && k >= 3 && (k % 2) == 1) ? 3'b001 : 3'b000,
          (!REP && k >= 5) ? 2'd0 : 2'd1, 0, 0);
      add(0, 1, 0, 0, 3'b000, (!REP && k >= 5) ? 2'd0 : 2'd1, 0, 0);
    end
    count_en = 1'b1;
    runTable("held_up");
    count_en = 1'b0;
    vectors++;
    if (pulses != (REP ? 5 : 1)) begin
      miscompares++;
      $display("[TB] FAIL held_up_count: got %0d sec pulses, want %0d", pulses, REP ? 5 : 1);
    end
    i_btn_up = 1'b0;
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
